// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the bit-serial adder sequencer: the state encoding
// and the default operand width.
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// ha / fa_cell
// One-bit full adder built from two half adders plus an OR for the carry.
// Purely combinational.
//
// ha ports:
//   i_a, i_b  : operand bits
//   o_s       : i_a ^ i_b
//   o_c       : i_a & i_b
// fa_cell ports:
//   i_a, i_b  : operand bits
//   i_cin     : carry in
//   o_s       : sum bit
//   o_cout    : carry out (majority of the three inputs)
// -----------------------------------------------------------------------------
module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_s1, w_c1, w_c2;

  ha u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1), .o_c(w_c1));
  ha u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s),  .o_c(w_c2));

  // The two half-adder carries can never both be 1, so OR equals majority.
  assign o_cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Sequencer for the shared one-bit adder. On an accepted start it captures
// a WIDTH-bit operand pair and streams one bit per enabled cycle, LSB first,
// through a single fa_cell. The full result and final carry are loaded into
// the output registers in one step on entry to DONE, so partial sums are
// never visible.
//
// Build option: define SERIAL_SUB_EN to add the 'sub' input. With sub=1 the
// B operand is inverted and the carry seeded with 1 (two's-complement
// subtract); carry_out=1 then means no borrow.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   ena        : clock enable, low freezes every register
//   start      : request, sampled only in IDLE
//   op_a, op_b : operands, captured on accepted start
//   sub        : (SERIAL_SUB_EN only) subtract select, captured with operands
//   busy       : high in RUN and DONE
//   done       : one enabled cycle pulse in DONE
//   sum        : result, held until the next completion
//   carry_out  : final carry, held with sum
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int           CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Holds the WIDTH-1 bits already produced; the last bit is joined on load.
  logic [WIDTH-2:0] r_res_sr;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;
  logic             w_s;
  logic             w_c_next;

`ifdef SERIAL_SUB_EN
  assign w_b_load = sub ? ~op_b : op_b;
  assign w_c_init = sub;
`else
  assign w_b_load = op_b;
  assign w_c_init = 1'b0;
`endif

  fa_cell u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_c_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_c      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= op_a;
            r_b_sr  <= w_b_load;
            r_c     <= w_c_init;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= (WIDTH-1)'({w_s, r_res_sr} >> 1);
          r_c      <= w_c_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= {w_s, r_res_sr};
            r_carry <= w_c_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for the shared one-bit adder resource. Accepts a WIDTH-bit operand pair on a start pulse and streams one bit per cycle, LSB first, through a single full-adder cell built from two half adders. It accumulates the sum and final carry, then signals completion. It sits between the user-input decode and the output/seven-segment drive logic.

Parameters:
WIDTH, 8, operand/result width in bits (2..16)
CW, $clog2(WIDTH), bit-counter width (derived localparam, not overridable)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; low = all state frozen
start  input  1  request; sampled only in IDLE with ena high
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse (high in DONE)
sum  output  WIDTH  registered result, held until next completion
carry_out  output  1  registered final carry, held with sum

Behaviour:
- Reset (async, rst_n low): state=IDLE; counter=0; shift regs=0; carry reg=0; busy=0, done=0, sum=0, carry_out=0.
- States: IDLE, RUN, DONE. All transitions are qualified by ena=1. With ena=0 nothing changes, including counter and done.
- IDLE: if start=1, capture op_a and op_b into shift regs, clear the carry reg and counter, and go to RUN. Otherwise stay.
- RUN, one bit per cycle:
  - s = a_sr[0]^b_sr[0]^c; c_next = majority(a_sr[0], b_sr[0], c).
  - a_sr and b_sr shift right; res_sr <= {s, res_sr[WIDTH-1:1]}; counter++.
  - When counter==WIDTH-1 at the edge, load sum <= {s, res_sr[WIDTH-1:1]} and carry_out <= c_next, then go to DONE.
- DONE: done=1 for exactly one enabled cycle, then IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start in RUN or DONE is ignored, not queued. The bench must re-assert it in IDLE.
- Operand inputs may change freely after capture. sum and carry_out update only on entry to DONE and never show partial results.
- Overflow wraps modulo 2^WIDTH. The lost bit appears only in carry_out.
- Reset mid-RUN aborts the operation. Outputs clear to 0 and no done is issued.
- ena deasserted mid-RUN stretches latency by the number of disabled cycles. The result is identical to an uninterrupted run.

Optional Feature:
SERIAL_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands on start. When sub=1, b_sr loads ~op_b and the carry reg initialises to 1, giving sum = op_a - op_b mod 2^WIDTH. carry_out=1 means no borrow (op_a >= op_b).
- Undefined: port absent; add only; carry initialises to 0.

Decomposition:
- Package serial_add_pkg contains:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- Sub-module fa_cell: one-bit full adder built from two ha instances plus an OR for carry. It is purely combinational. The controller instantiates exactly one.
- The controller holds the FSM, counter, shift regs and output registers.

Test Plan:
1. WIDTH=8, reset then start with op_a=0x3C, op_b=0x05 -> done pulses 9 cycles after the start edge; sum=0x41, carry_out=0; busy high for exactly 9 cycles.
2. op_a=0xFF, op_b=0x01 -> sum=0x00, carry_out=1. Then op_a=0x80, op_b=0x80 -> sum=0x00, carry_out=1. sum holds 0x00 until the next done.
3. Start held high continuously with op_a=0x12, op_b=0x34 -> a new operation every 10 cycles, each sum=0x46. Pulsing start during RUN has no effect on the result or timing.
4. Start 0xAA+0x55, drop ena for 3 cycles mid-RUN -> done arrives 12 cycles after start; sum=0xFF, carry_out=0.
5. Start 0x0F+0x01, assert rst_n=0 at RUN bit 4 -> busy, done, sum and carry_out are 0 immediately. After release, IDLE with no spurious done.
6. With SERIAL_SUB_EN: sub=1, op_a=0x10, op_b=0x01 -> sum=0x0F, carry_out=1. Then op_a=0x01, op_b=0x02 -> sum=0xFF, carry_out=0.
